// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - OP_* : M-extension funct3 encodings accepted on the op port.
//   - state_e : control FSM state encoding.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // True for ops whose rs1 operand is interpreted as signed.
  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // True for ops whose rs2 operand is interpreted as signed.
  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative multiply/divide datapath.
//   clk, rst     : clock, synchronous active-high reset
//   load         : capture op and operand magnitudes/sign flags (and fast result if fast)
//   step         : perform one shift-add or restoring-divide iteration
//   finish       : sign-fix the stepped accumulator into the result register
//   op, a, b     : operation and operands, sampled only on load
//   fast         : current op/operands resolve without iterating
//   result       : registered result, held until the next load/finish
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            finish,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            fast,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // Operand decode (only meaningful on load).
  logic            neg_a, neg_b, b_zero, ovf;
  logic [XLEN-1:0] mag_a, mag_b, fast_res;

  always_comb begin
    neg_a  = op_a_signed(op) & a[XLEN-1];
    neg_b  = op_b_signed(op) & b[XLEN-1];
    mag_a  = neg_a ? -a : a;
    mag_b  = neg_b ? -b : b;
    b_zero = (b == '0);
    ovf    = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1);
    fast   = op[2] && (b_zero || ovf);
    // op[1] distinguishes REM/REMU from DIV/DIVU.
    if (b_zero) begin
      fast_res = op[1] ? a : '1;
    end else begin
      fast_res = op[1] ? '0 : a;
    end
  end

  // acc_q: multiply {partial product hi, remaining multiplier}; divide {remainder, dividend/quotient}.
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   mag_b_q;
  logic [2:0]        op_q;
  logic              neg_res_q;  // product or quotient is negated
  logic              neg_rem_q;  // remainder is negated
  logic [XLEN-1:0]   result_q;

  logic [2*XLEN-1:0] acc_step, prod;
  logic [XLEN:0]     sum, cand, diff;
  logic [XLEN-1:0]   quo, rem, fixed;

  always_comb begin
    sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
    cand = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff = cand - {1'b0, mag_b_q};
    if (op_q[2]) begin
      // Borrow out of diff means the trial subtraction is undone.
      if (!diff[XLEN]) begin
        acc_step = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_step = {cand[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_step = {sum, acc_q[XLEN-1:1]};
    end

    prod = neg_res_q ? -acc_step : acc_step;
    quo  = neg_res_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem  = neg_rem_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    if (op_q[2]) begin
      fixed = op_q[1] ? rem : quo;
    end else begin
      fixed = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      mag_b_q   <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else if (load) begin
      acc_q     <= {{XLEN{1'b0}}, mag_a};
      mag_b_q   <= mag_b;
      op_q      <= op;
      neg_res_q <= neg_a ^ neg_b;
      neg_rem_q <= neg_a;
      if (fast) begin
        result_q <= fast_res;
      end
    end else begin
      if (step) begin
        acc_q <= acc_step;
      end
      if (finish) begin
        result_q <= fixed;
      end
    end
  end

  assign result = result_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit with valid/ready handshakes.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : op acceptance handshake (in_ready only in IDLE)
//   op, a, b, tag_in      : funct3, rs1, rs2, destination tag
//   flush                 : kill in-flight op / block acceptance
//   out_valid/out_ready   : result handshake
//   result, tag_out       : result and its destination tag
//   busy                  : unit not idle
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);

  localparam int unsigned     CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TAG_W-1:0]  tag_q;
  logic              load, step, finish, fast;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = fast ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            finish  = 1'b1;
            cnt_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (flush || out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        tag_q <= tag_in;
      end
    end
  end

  muldiv_datapath #(
    .XLEN (XLEN)
  ) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .finish (finish),
    .op     (op),
    .a      (a),
    .b      (b),
    .fast   (fast),
    .result (result)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign tag_out   = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed cases plus randomized ops
// checked against a plain-arithmetic RISC-V M reference model.
module tb_muldiv_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       op = '0;
  logic [XLEN-1:0]  a = '0;
  logic [XLEN-1:0]  b = '0;
  logic [TAG_W-1:0] tag_in = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_out;
  logic             busy;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(
    .XLEN  (XLEN),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .tag_in    (tag_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .tag_out   (tag_out),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RISC-V M semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x,
                                            input logic [31:0] y);
    longint      sx, sy, ux, uy, q;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    case (f)
      3'd0: begin p = 64'(sx * sy); return p[31:0]; end
      3'd1: begin p = 64'(sx * sy); return p[63:32]; end
      3'd2: begin p = 64'(sx * uy); return p[63:32]; end
      3'd3: begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        q = sx / sy;  // 2^31 fits in longint, truncating toward zero
        p = 64'(q);
        return p[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        q = ux / uy;
        p = 64'(q);
        return p[31:0];
      end
      3'd6: begin
        if (y == 0) return x;
        q = sx % sy;
        p = 64'(q);
        return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        q = ux % uy;
        p = 64'(q);
        return p[31:0];
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] x,
                                     input logic [31:0] y);
    logic is_div, signed_div, overflow;
    is_div     = (f >= 3'd4);
    signed_div = (f == 3'd4) || (f == 3'd6);
    overflow   = signed_div && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    return (is_div && ((y == 0) || overflow)) ? 1 : XLEN + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op for one cycle (acceptance edge), then scramble the inputs.
  task automatic start_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] tg);
    op       = f;
    a        = x;
    b        = y;
    tag_in   = tg;
    in_valid = 1'b1;
    check_eq("in_ready_before_accept", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    op       = 3'($urandom);
    a        = $urandom;
    b        = $urandom;
    tag_in   = 5'($urandom);
  endtask

  // Cycles after acceptance until out_valid is seen (1 = cycle T+1); 101 on timeout.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat <= 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp_v);
    logic [4:0] tg;
    int         lat;
    tg = 5'($urandom);
    start_op(f, x, y, tg);
    wait_valid(lat);
    check_eq({name, "_latency"}, 64'(lat), 64'(exp_latency(f, x, y)));
    check_eq({name, "_result"}, 64'(result), 64'(exp_v));
    check_eq({name, "_tag"}, 64'(tag_out), 64'(tg));
    tick();
    check_eq({name, "_out_valid_cleared"}, 64'(out_valid), 64'd0);
    check_eq({name, "_in_ready_after"}, 64'(in_ready), 64'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check_eq({name, "_in_ready"}, 64'(in_ready), 64'd1);
    check_eq({name, "_out_valid"}, 64'(out_valid), 64'd0);
    check_eq({name, "_busy"}, 64'(busy), 64'd0);
    check_eq({name, "_result"}, 64'(result), 64'd0);
    check_eq({name, "_tag_out"}, 64'(tag_out), 64'd0);
  endtask

  initial begin
    int          lat;
    logic        seen;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    // Reset state.
    rst = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Latency, encoding, mixed signedness.
    do_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    do_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    do_op("mulhu_min", 3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    do_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Divide.
    do_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    do_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    do_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14);
    do_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2);

    // Fast paths.
    do_op("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
    do_op("rem_by0", 3'd6, 32'd5, 32'd0, 32'd5);
    do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Back-pressure: result/tag held, no acceptance while DONE.
    out_ready = 1'b0;
    start_op(3'd5, 32'd100, 32'd7, 5'd9);
    in_valid = 1'b1;  // offered while DONE must not be taken
    wait_valid(lat);
    check_eq("bp_latency", 64'(lat), 64'(XLEN + 1));
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp_out_valid", 64'(out_valid), 64'd1);
      check_eq("bp_result", 64'(result), 64'd14);
      check_eq("bp_tag", 64'(tag_out), 64'd9);
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_eq("bp_in_ready_after", 64'(in_ready), 64'd1);
    check_eq("bp_out_valid_after", 64'(out_valid), 64'd0);

    // Flush in IDLE blocks acceptance (a fast op would otherwise be valid next cycle).
    op = 3'd5; a = 32'd5; b = 32'd0; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check_eq("idle_flush_busy", 64'(busy), 64'd0);
    check_eq("idle_flush_out_valid", 64'(out_valid), 64'd0);
    check_eq("idle_flush_in_ready", 64'(in_ready), 64'd1);

    // Flush at counter 10 of a DIV.
    start_op(3'd4, 32'hFFFF_FF9C, 32'd3, 5'd4);
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flush_busy_in_ready", 64'(in_ready), 64'd1);
    check_eq("flush_busy_out_valid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check_eq("flush_busy_never_valid", 64'(seen), 64'd0);
    do_op("mul_3_4", 3'd0, 32'd3, 32'd4, 32'd12);

    // Flush while DONE overrides a pending result.
    out_ready = 1'b0;
    start_op(3'd3, 32'd6, 32'd7, 5'd2);
    wait_valid(lat);
    check_eq("flush_done_valid_seen", 64'(out_valid), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    check_eq("flush_done_out_valid", 64'(out_valid), 64'd0);
    check_eq("flush_done_in_ready", 64'(in_ready), 64'd1);

    // Randomized ops with biased corner operands.
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      do_op("rand", rf, ra, rb, ref_model(rf, ra, rb));
    end

    // Reset mid-iteration.
    start_op(3'd0, 32'd123, 32'd456, 5'd17);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("rst_mid_busy");
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle successor to the core's single-cycle integer ALU.
- Executes the RV32M/RV64M multiply and divide group (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Uses iterative shift-add and restoring-divide datapaths with valid/ready handshakes.
- Sits beside the ALU in EX. The pipeline stalls on in_ready/out_valid, and a flush kills an in-flight op.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- TAG_W, 5, width of the destination-register tag carried alongside the op.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  unit can accept; high only in IDLE
- op  in  3  M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  XLEN  rs1 operand
- b  in  XLEN  rs2 operand
- tag_in  in  TAG_W  rd index
- flush  in  1  kill current op
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  XLEN  result
- tag_out  out  TAG_W  rd of result
- busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; busy=0; result=0; tag_out=0; counter=0.
- States and transitions:
  - IDLE:
    - Accept when in_valid && in_ready (cycle T).
    - Latch op, tag, |a|, |b| and result-sign flags.
    - Go to DONE on a fast path, else to BUSY.
  - BUSY:
    - One iteration per cycle, counter counts 0..XLEN-1.
    - After the iteration with counter==XLEN-1, apply sign fix and go to DONE.
    - Latency: accept at T, out_valid first high at T+XLEN+1.
  - DONE:
    - out_valid=1, result and tag_out held stable.
    - When out_valid && out_ready, go to IDLE. in_ready rises the cycle after the handshake.
    - No same-cycle accept in DONE.
- Fast paths (out_valid at T+1):
  - b==0, DIV/DIVU: quotient = all ones.
  - b==0, REM/REMU: remainder = a.
  - Signed overflow (a = most negative, b = -1), DIV: result = a.
  - Signed overflow, REM: result = 0.
- Multiply:
  - Shift-add on magnitudes into a 2*XLEN accumulator.
  - MUL returns the low XLEN bits. MULH/MULHSU/MULHU return the high XLEN bits.
  - Signedness: MULH = a and b signed; MULHSU = a signed, b unsigned; MULHU = both unsigned.
  - Negate the 2*XLEN product when the operand signs differ (only for the signed operands).
- Divide:
  - Restoring divide on magnitudes, one quotient bit per cycle.
  - Signed quotient is negative iff sign(a) != sign(b) (b != 0). Signed remainder takes the sign of a.
  - Results conform exactly to the RISC-V M spec, including truncation toward zero.
- flush:
  - In BUSY or DONE: go to IDLE next cycle; out_valid=0 next cycle; result discarded.
  - Flush has priority over the counter completing and over out_ready.
  - Flush in IDLE concurrent with in_valid: the op is not accepted.
- rst has priority over everything, including mid-iteration. The unit returns to IDLE in one cycle.
- Inputs a/b/op may change after acceptance without effect.

Decomposition:
- Shared package holds:
  - op localparams (OP_MUL..OP_REMU) with funct3 values.
  - State encodings (S_IDLE=2'd0, S_BUSY=2'd1, S_DONE=2'd2).
- One natural sub-module: muldiv_datapath, holding the accumulator/remainder registers, iteration step and sign-fix logic. The parent holds the FSM, counter and handshake.

Test Plan (XLEN=32):
1. Latency and encoding: MUL a=7, b=-3 -> result 0xFFFFFFEB, out_valid at exactly T+33, tag echoed.
2. Mixed signedness:
   - MULH a=0x80000000, b=0x80000000 -> 0x40000000.
   - MULHU same operands -> 0x40000000.
   - MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
3. Signed divide:
   - DIV a=-7, b=2 -> 0xFFFFFFFD.
   - REM same operands -> 0xFFFFFFFF.
   - DIVU a=100, b=7 -> 14.
   - REMU a=100, b=7 -> 2.
4. Fast paths:
   - DIVU a=5, b=0 -> 0xFFFFFFFF at T+1.
   - REM a=5, b=0 -> 5.
   - DIV a=0x80000000, b=-1 -> 0x80000000.
   - REM same operands -> 0.
5. Back-pressure: out_ready=0 for 10 cycles after out_valid -> result/tag stable, in_ready=0. out_ready=1 -> IDLE, in_ready=1 next cycle.
6. Kill and reset: flush at counter=10 of a DIV -> out_valid never asserts, in_ready=1 next cycle. New MUL 3×4 -> 12. rst asserted mid-BUSY -> all outputs at reset values next cycle.
